// File: rtl/mux_share_arbiter.sv
// ---------------------------------------------------------------------------
// mux_share_arbiter
//
// Purpose:
//   Shares a single WIDTH-bit 2:1 mux between two requesters using a
//   round-robin arbiter. The arbiter picks an owner, drives the mux select and
//   registers the selected data together with a valid flag. A hold counter
//   caps how long one requester may keep the mux while the other is waiting,
//   so neither side can starve the other.
//
// Parameters:
//   WIDTH     data width of In_0, In_1 and Out
//   MAX_HOLD  max consecutive owned cycles while the other side waits (>= 1)
//
// Ports:
//   CLK        in   1      rising-edge clock
//   RESET      in   1      asynchronous, active-high reset
//   Req_0      in   1      requester 0 wants the mux
//   Req_1      in   1      requester 1 wants the mux
//   In_0       in   WIDTH  requester 0 data (mux input 0)
//   In_1       in   WIDTH  requester 1 data (mux input 1)
//   Grant_0    out  1      requester 0 owns the mux this cycle
//   Grant_1    out  1      requester 1 owns the mux this cycle
//   Select     out  1      mux select, 1 = In_1
//   Out        out  WIDTH  registered mux output
//   Out_Valid  out  1      Out holds data sampled during a grant
// ---------------------------------------------------------------------------
module mux_share_arbiter #(
    parameter int WIDTH    = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Req_0,
    input  logic             Req_1,
    input  logic [WIDTH-1:0] In_0,
    input  logic [WIDTH-1:0] In_1,
    output logic             Grant_0,
    output logic             Grant_1,
    output logic             Select,
    output logic [WIDTH-1:0] Out,
    output logic             Out_Valid
);

    localparam int CW = $clog2(MAX_HOLD) + 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    hold_cnt_q, hold_cnt_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0] out_q;
    logic             out_valid_q;

    // Arbitration state, hold counter and round-robin pointer. Everything
    // the outputs depend on lives in these registers, so there is no
    // combinational path from a request to a grant.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            rr_ptr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    // Next-state logic. An owner keeps the mux while it requests, except that
    // once it has held for MAX_HOLD cycles with the other side waiting it is
    // forced to hand over. Handover goes straight from one OWN state to the
    // other so the mux never idles while someone is asking for it.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        rr_ptr_d   = rr_ptr_q;

        unique case (state_q)
            IDLE: begin
                if (Req_0 && Req_1) begin
                    state_d = rr_ptr_q ? OWN1 : OWN0;
                end else if (Req_0) begin
                    state_d = OWN0;
                end else if (Req_1) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (!Req_0) begin
                    state_d = Req_1 ? OWN1 : IDLE;
                end else if (Req_1 && (hold_cnt_q == HOLD_LAST)) begin
                    state_d = OWN1;
                end
            end
            OWN1: begin
                if (!Req_1) begin
                    state_d = Req_0 ? OWN0 : IDLE;
                end else if (Req_0 && (hold_cnt_q == HOLD_LAST)) begin
                    state_d = OWN0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Entering an OWN state restarts the hold count and points the
        // round-robin preference at the other requester. Staying in an OWN
        // state counts up and parks at the limit, so a long solo owner hands
        // over on the very next edge once the other side starts requesting.
        if ((state_d != IDLE) && (state_d != state_q)) begin
            hold_cnt_d = '0;
            rr_ptr_d   = (state_d == OWN0);
        end else if ((state_d != IDLE) && (hold_cnt_q != HOLD_LAST)) begin
            hold_cnt_d = hold_cnt_q + CW'(1);
        end
    end

    // Registered datapath: capture the owner's data during a grant and hold
    // it otherwise. Valid trails the state by one edge, so it drops one cycle
    // after the arbiter returns to IDLE.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (state_q != IDLE) begin
                out_q <= (state_q == OWN1) ? In_1 : In_0;
            end
            out_valid_q <= (state_q != IDLE);
        end
    end

    assign Grant_0   = (state_q == OWN0);
    assign Grant_1   = (state_q == OWN1);
    assign Select    = (state_q == OWN1);
    assign Out       = out_q;
    assign Out_Valid = out_valid_q;

endmodule

// File: tb/tb_mux_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux_share_arbiter
//
// Self-checking bench for mux_share_arbiter (WIDTH=4, MAX_HOLD=4). Each
// scenario task drives inputs on the falling edge, pushes the outputs it
// expects after the next rising edge onto a scoreboard queue, then pops and
// compares shortly after that edge. Expected values are packed as
// {Grant_0, Grant_1, Select, Out[3:0], Out_Valid}.
// ---------------------------------------------------------------------------
module tb_mux_share_arbiter;

    logic       CLK;
    logic       RESET;
    logic       Req_0;
    logic       Req_1;
    logic [3:0] In_0;
    logic [3:0] In_1;
    logic       Grant_0;
    logic       Grant_1;
    logic       Select;
    logic [3:0] Out;
    logic       Out_Valid;

    logic [7:0] expQ[$];
    int         checks;
    int         errors;

    wire  [7:0] obs = {Grant_0, Grant_1, Select, Out, Out_Valid};

    mux_share_arbiter #(
        .WIDTH    (4),
        .MAX_HOLD (4)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .Req_0     (Req_0),
        .Req_1     (Req_1),
        .In_0      (In_0),
        .In_1      (In_1),
        .Grant_0   (Grant_0),
        .Grant_1   (Grant_1),
        .Select    (Select),
        .Out       (Out),
        .Out_Valid (Out_Valid)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, limit 200000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] mkExp(input logic g0, input logic g1, input logic sel,
                                         input logic [3:0] o, input logic v);
        return {g0, g1, sel, o, v};
    endfunction

    // Puts the DUT back into its reset state with no requests pending.
    task automatic resetDut();
        @(negedge CLK);
        RESET = 1'b1;
        Req_0 = 1'b0;
        Req_1 = 1'b0;
        In_0  = 4'h0;
        In_1  = 4'h0;
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    // Reset held with both requesters asking: outputs stay zero, then
    // requester 0 wins one cycle after release.
    task automatic test_reset();
        logic [7:0] e;
        for (int c = 1; c <= 4; c++) begin
            @(negedge CLK);
            case (c)
                1: begin
                    RESET = 1'b1; Req_0 = 1'b1; Req_1 = 1'b1; In_0 = 4'hF; In_1 = 4'hF;
                    expQ.push_back(mkExp(0, 0, 0, 4'h0, 0));
                end
                2, 3: expQ.push_back(mkExp(0, 0, 0, 4'h0, 0));
                default: begin
                    RESET = 1'b0;
                    expQ.push_back(mkExp(1, 0, 0, 4'h0, 0));
                end
            endcase
            @(posedge CLK); #1;
            e = expQ.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL reset c%0d: got {g0,g1,sel,out,v}=%b expected %b", c, obs, e);
            end
        end
    endtask

    // Single requester: grant, data capture, then release and valid drop.
    // Data changed after the grant ends must not reach Out.
    task automatic test_single();
        logic [7:0] e;
        resetDut();
        for (int c = 1; c <= 4; c++) begin
            @(negedge CLK);
            case (c)
                1: begin Req_0 = 1'b1; In_0 = 4'b0101; expQ.push_back(mkExp(1, 0, 0, 4'h0, 0)); end
                2: expQ.push_back(mkExp(1, 0, 0, 4'b0101, 1));
                3: begin Req_0 = 1'b0; expQ.push_back(mkExp(0, 0, 0, 4'b0101, 1)); end
                default: begin In_0 = 4'h3; expQ.push_back(mkExp(0, 0, 0, 4'b0101, 0)); end
            endcase
            @(posedge CLK); #1;
            e = expQ.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL single c%0d: got {g0,g1,sel,out,v}=%b expected %b", c, obs, e);
            end
        end
    endtask

    // Both requesters held: 4-cycle ownership runs alternate, Out follows one
    // cycle behind, and the grants are never both high.
    task automatic test_rotation();
        logic [7:0] e;
        int         owner;
        int         prevOwner;
        resetDut();
        for (int k = 1; k <= 17; k++) begin
            @(negedge CLK);
            Req_0 = 1'b1;
            Req_1 = 1'b1;
            In_0  = 4'b0101;
            In_1  = 4'b1010;
            owner     = ((k - 1) / 4) % 2;
            prevOwner = ((k - 2) / 4) % 2;
            if (k == 1) begin
                expQ.push_back(mkExp(1, 0, 0, 4'h0, 0));
            end else begin
                expQ.push_back(mkExp(owner == 0, owner == 1, owner == 1,
                                     (prevOwner == 0) ? 4'b0101 : 4'b1010, 1));
            end
            @(posedge CLK); #1;
            e = expQ.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL rotation k%0d: got {g0,g1,sel,out,v}=%b expected %b", k, obs, e);
            end
            checks++;
            if (Grant_0 && Grant_1) begin
                errors++;
                $display("[TB] FAIL rotation_excl k%0d: got Grant_0=%b Grant_1=%b expected at most one", k, Grant_0, Grant_1);
            end
        end
    endtask

    // Owner 0 drops while requester 1 waits: back-to-back handover to 1.
    task automatic test_drop_handover();
        logic [7:0] e;
        resetDut();
        for (int c = 1; c <= 6; c++) begin
            @(negedge CLK);
            case (c)
                1: begin
                    Req_0 = 1'b1; Req_1 = 1'b1; In_0 = 4'h3; In_1 = 4'hC;
                    expQ.push_back(mkExp(1, 0, 0, 4'h0, 0));
                end
                2: expQ.push_back(mkExp(1, 0, 0, 4'h3, 1));
                3: begin Req_0 = 1'b0; expQ.push_back(mkExp(0, 1, 1, 4'h3, 1)); end
                4: expQ.push_back(mkExp(0, 1, 1, 4'hC, 1));
                5: begin Req_1 = 1'b0; expQ.push_back(mkExp(0, 0, 0, 4'hC, 1)); end
                default: expQ.push_back(mkExp(0, 0, 0, 4'hC, 0));
            endcase
            @(posedge CLK); #1;
            e = expQ.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL drop_handover c%0d: got {g0,g1,sel,out,v}=%b expected %b", c, obs, e);
            end
        end
    endtask

    // Requester 1 owns alone, requester 0 joins: 1 keeps exactly 4 cycles.
    task automatic test_hold_limit();
        logic [7:0] e;
        resetDut();
        for (int c = 1; c <= 6; c++) begin
            @(negedge CLK);
            case (c)
                1: begin
                    Req_1 = 1'b1; In_0 = 4'h9; In_1 = 4'h6;
                    expQ.push_back(mkExp(0, 1, 1, 4'h0, 0));
                end
                2: begin Req_0 = 1'b1; expQ.push_back(mkExp(0, 1, 1, 4'h6, 1)); end
                3, 4: expQ.push_back(mkExp(0, 1, 1, 4'h6, 1));
                5: expQ.push_back(mkExp(1, 0, 0, 4'h6, 1));
                default: expQ.push_back(mkExp(1, 0, 0, 4'h9, 1));
            endcase
            @(posedge CLK); #1;
            e = expQ.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL hold_limit c%0d: got {g0,g1,sel,out,v}=%b expected %b", c, obs, e);
            end
        end
    endtask

    // Long solo ownership parks the hold count at its limit, so a newly
    // arriving requester 1 takes over on the very next edge.
    task automatic test_saturation();
        logic [7:0] e;
        resetDut();
        for (int c = 1; c <= 8; c++) begin
            @(negedge CLK);
            Req_0 = 1'b1;
            In_0  = 4'h1;
            In_1  = 4'h7;
            if (c == 1) begin
                expQ.push_back(mkExp(1, 0, 0, 4'h0, 0));
            end else if (c <= 6) begin
                expQ.push_back(mkExp(1, 0, 0, 4'h1, 1));
            end else if (c == 7) begin
                Req_1 = 1'b1;
                expQ.push_back(mkExp(0, 1, 1, 4'h1, 1));
            end else begin
                expQ.push_back(mkExp(0, 1, 1, 4'h7, 1));
            end
            @(posedge CLK); #1;
            e = expQ.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL saturation c%0d: got {g0,g1,sel,out,v}=%b expected %b", c, obs, e);
            end
        end
    endtask

    // Reset pulsed between clock edges while requester 1 owns: outputs clear
    // at once, and requester 0 wins afterwards.
    task automatic test_reset_mid_grant();
        logic [7:0] e;
        resetDut();
        for (int c = 1; c <= 4; c++) begin
            if (c == 3) begin
                #2;
                RESET = 1'b1;
                Req_0 = 1'b1;
                Req_1 = 1'b1;
                expQ.push_back(mkExp(0, 0, 0, 4'h0, 0));
                #1;
            end else begin
                @(negedge CLK);
                case (c)
                    1: begin Req_1 = 1'b1; In_1 = 4'hE; In_0 = 4'h2; expQ.push_back(mkExp(0, 1, 1, 4'h0, 0)); end
                    2: expQ.push_back(mkExp(0, 1, 1, 4'hE, 1));
                    default: begin RESET = 1'b0; expQ.push_back(mkExp(1, 0, 0, 4'h0, 0)); end
                endcase
                @(posedge CLK); #1;
            end
            e = expQ.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL reset_mid_grant c%0d: got {g0,g1,sel,out,v}=%b expected %b", c, obs, e);
            end
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        checks = 0;
        errors = 0;
        RESET  = 1'b1;
        Req_0  = 1'b0;
        Req_1  = 1'b0;
        In_0   = 4'h0;
        In_1   = 4'h0;

        test_reset();
        test_single();
        test_rotation();
        test_drop_handover();
        test_hold_limit();
        test_saturation();
        test_reset_mid_grant();

        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d leftover entries expected 0", expQ.size());
        end
        checks++;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
